// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer for a small RISC-V datapath (R-type, ld, sd, beq).
// Steps each instruction through FETCH/DECODE/... and drives the datapath
// strobes and mux selects.
//
// Optional build macro: MULTICYCLE_PERF_CNT_EN
//   defined   -> cycle_cnt / instr_cnt performance counters are built
//   undefined -> both counter outputs are tied to 0
//
// Moore selects are registered: they are loaded from the decode of the next
// state, so they are valid in the same cycle the state register changes.
// The two strobes that depend on same-cycle inputs (ir_write, pc_write) are
// Mealy and combinational. Every output is gated with rst_n so that the whole
// interface reads 0 while reset is held.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_src,
    output logic             reg_write,
    output logic             illegal,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LD    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    // Moore outputs, all a pure function of the state
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       reg_write;
        logic       illegal;
    } moore_t;

    function automatic moore_t moore_decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_read  = 1'b1;
                m.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                m.alu_src_b = 2'b10;
            end
            S_MEM_ADDR: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                m.mem_read = 1'b1;
                m.i_or_d   = 1'b1;
            end
            S_WB_LD: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                m.mem_write = 1'b1;
                m.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = 2'b10;
            end
            S_WB_R: begin
                m.reg_write = 1'b1;
            end
            S_BRANCH: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = 2'b01;
                m.pc_src    = 1'b1;
            end
            S_HALT: begin
                m.illegal = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    state_t state_reg;
    state_t state_next;
    moore_t moore_reg;

    // Next-state selection; memory states hold until mem_ready
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_R)
                    state_next = S_EXEC_R;
                else if (opcode == OP_LD || opcode == OP_SD)
                    state_next = S_MEM_ADDR;
                else if (opcode == OP_BEQ)
                    state_next = S_BRANCH;
                else
                    state_next = S_HALT;
            end
            S_MEM_ADDR: state_next = (opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_next = mem_ready ? S_WB_LD : S_MEM_RD;
            S_WB_LD:    state_next = S_FETCH;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_next = S_WB_R;
            S_WB_R:     state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_HALT;
        endcase
    end

    // State register plus registered Moore outputs for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            moore_reg <= moore_decode(S_FETCH);
        end else begin
            state_reg <= state_next;
            moore_reg <= moore_decode(state_next);
        end
    end

    logic fetch_done;
    logic branch_taken;

    assign fetch_done   = rst_n && (state_reg == S_FETCH) && mem_ready;
    assign branch_taken = rst_n && (state_reg == S_BRANCH) && zero;

    assign ir_write   = fetch_done;
    assign pc_write   = fetch_done || branch_taken;
    assign mem_read   = rst_n && moore_reg.mem_read;
    assign mem_write  = rst_n && moore_reg.mem_write;
    assign i_or_d     = rst_n && moore_reg.i_or_d;
    assign mem_to_reg = rst_n && moore_reg.mem_to_reg;
    assign alu_src_a  = rst_n && moore_reg.alu_src_a;
    assign alu_src_b  = rst_n ? moore_reg.alu_src_b : 2'b00;
    assign alu_op     = rst_n ? moore_reg.alu_op : 2'b00;
    assign pc_src     = rst_n && moore_reg.pc_src;
    assign reg_write  = rst_n && moore_reg.reg_write;
    assign illegal    = rst_n && moore_reg.illegal;
    assign state_dbg  = rst_n ? state_reg : 4'd0;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;
    logic             retire;

    // Last cycle of each instruction; a store retires only when its write lands
    assign retire = (state_reg == S_WB_LD) || (state_reg == S_WB_R) ||
                    (state_reg == S_BRANCH) ||
                    ((state_reg == S_MEM_WR) && mem_ready);

    // Free-running counters, frozen while halted, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            if (state_reg != S_HALT)
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (retire)
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             pc_src;
    logic             reg_write;
    logic             illegal;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state_dbg  (state_dbg),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_read, mem_write, reg_write, pc_write, ir_write}
    function automatic logic [4:0] strobes();
        return {mem_read, mem_write, reg_write, pc_write, ir_write};
    endfunction

    // {i_or_d, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal}
    function automatic logic [8:0] selects();
        return {i_or_d, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 7'b0110011;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({state_dbg, strobes(), selects()} !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold outputs=%h required=0", {state_dbg, strobes(), selects()});
        end
        checks++;
        if ({cycle_cnt, instr_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters cycle=%0d instr=%0d required=0", cycle_cnt, instr_cnt);
        end
        $display("reset held: state=%0d strobes=%b", state_dbg, strobes());
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || strobes() !== 5'b10011 || alu_src_b !== 2'b01) begin
            errors++;
            $display("FAIL reset_release state=%0d strobes=%b alu_src_b=%b required 0/10011/01",
                     state_dbg, strobes(), alu_src_b);
        end
        tick(); tick();
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd6) begin
            errors++;
            $display("FAIL reset_reach_exec state=%0d required=6", state_dbg);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state_dbg, strobes(), selects()} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_exec outputs=%h required=0", {state_dbg, strobes(), selects()});
        end
        $display("reset mid EXEC_R: state=%0d selects=%b", state_dbg, selects());
        tick(); tick();
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || strobes() !== 5'b10000) begin
            errors++;
            $display("FAIL reset_rerelease_wait state=%0d strobes=%b required 0/10000",
                     state_dbg, strobes());
        end
        tick();
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait_hold state=%0d ir_write=%b required 0/0", state_dbg, ir_write);
        end
        tick();
        mem_ready = 1'b1;
    endtask

    task automatic test_rtype();
        int exp_st [4] = '{0, 1, 6, 7};
        logic [4:0] exp_sb [4] = '{5'b10011, 5'b00000, 5'b00000, 5'b00100};
        logic [CNT_W-1:0] c0, i0;
        opcode = 7'b0110011; mem_ready = 1'b1;
        c0 = '0; i0 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin c0 = cycle_cnt; i0 = instr_cnt; end
            checks++;
            if (state_dbg !== 4'(exp_st[c]) || strobes() !== exp_sb[c]) begin
                errors++;
                $display("FAIL rtype_c%0d state=%0d strobes=%b required %0d/%b",
                         c + 1, state_dbg, strobes(), exp_st[c], exp_sb[c]);
            end
            if (c == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== 5'b10010) begin
                    errors++;
                    $display("FAIL rtype_exec_sel a=%b b=%b op=%b required 1/00/10",
                             alu_src_a, alu_src_b, alu_op);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL rtype_return state=%0d required=0", state_dbg);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        checks++;
        if (cycle_cnt - c0 !== 32'd4 || instr_cnt - i0 !== 32'd1) begin
            errors++;
            $display("FAIL rtype_counters dcycle=%0d dinstr=%0d required 4/1",
                     cycle_cnt - c0, instr_cnt - i0);
        end
`endif
        $display("R-type: done state=%0d cycle_cnt=%0d instr_cnt=%0d", state_dbg, cycle_cnt, instr_cnt);
        tick();
        // that tick consumed the next FETCH (mem_ready=1): state now DECODE; finish it as R
        tick(); tick(); tick();
    endtask

    task automatic test_ld();
        int exp_st [7] = '{0, 1, 2, 3, 3, 3, 4};
        logic rdy [7] = '{1, 1, 1, 0, 0, 1, 1};
        logic [4:0] exp_sb [7] = '{5'b10011, 5'b00000, 5'b00000, 5'b10000,
                                   5'b10000, 5'b10000, 5'b00100};
        logic [1:0] exp_im [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        opcode = 7'b0000011;
        for (int c = 0; c < 7; c++) begin
            mem_ready = rdy[c];
            @(negedge clk);
            checks++;
            if (state_dbg !== 4'(exp_st[c]) || strobes() !== exp_sb[c] ||
                {i_or_d, mem_to_reg} !== exp_im[c]) begin
                errors++;
                $display("FAIL ld_c%0d state=%0d strobes=%b iord_m2r=%b required %0d/%b/%b",
                         c + 1, state_dbg, strobes(), {i_or_d, mem_to_reg},
                         exp_st[c], exp_sb[c], exp_im[c]);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL ld_return state=%0d required=0", state_dbg);
        end
        $display("ld with 2 waits: done state=%0d", state_dbg);
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_sd();
        int exp_st [4] = '{0, 1, 2, 5};
        logic [4:0] exp_sb [4] = '{5'b10011, 5'b00000, 5'b00000, 5'b01000};
        opcode = 7'b0100011; mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (state_dbg !== 4'(exp_st[c]) || strobes() !== exp_sb[c]) begin
                errors++;
                $display("FAIL sd_c%0d state=%0d strobes=%b required %0d/%b",
                         c + 1, state_dbg, strobes(), exp_st[c], exp_sb[c]);
            end
            if (c == 2) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL sd_return state=%0d reg_write=%b required 0/0", state_dbg, reg_write);
        end
        $display("sd: done state=%0d", state_dbg);
        tick();
    endtask

    task automatic test_beq(input logic z);
        int exp_st [3] = '{0, 1, 8};
        logic [4:0] exp_sb [3];
        exp_sb[0] = 5'b10011; exp_sb[1] = 5'b00000; exp_sb[2] = {3'b000, z, 1'b0};
        opcode = 7'b1100011; zero = z; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (state_dbg !== 4'(exp_st[c]) || strobes() !== exp_sb[c]) begin
                errors++;
                $display("FAIL beq_z%0d_c%0d state=%0d strobes=%b required %0d/%b",
                         z, c + 1, state_dbg, strobes(), exp_st[c], exp_sb[c]);
            end
            if (c == 2) begin
                checks++;
                if ({pc_src, alu_src_a, alu_op} !== 4'b1101) begin
                    errors++;
                    $display("FAIL beq_sel pc_src=%b a=%b op=%b required 1/1/01",
                             pc_src, alu_src_a, alu_op);
                end
            end
            if (c == 2) mem_ready = 1'b0;
            tick();
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL beq_return state=%0d required=0", state_dbg);
        end
        $display("beq zero=%0d: done state=%0d", z, state_dbg);
        tick();
    endtask

    task automatic test_illegal();
        logic [CNT_W-1:0] c0, i0;
        opcode = 7'b0010011; mem_ready = 1'b1;
        @(negedge clk);
        i0 = instr_cnt;
        tick();
        tick();
        @(negedge clk);
        c0 = cycle_cnt;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (state_dbg !== 4'd9 || illegal !== 1'b1 || strobes() !== 5'b00000) begin
                errors++;
                $display("FAIL halt_c%0d state=%0d illegal=%b strobes=%b required 9/1/00000",
                         c, state_dbg, illegal, strobes());
            end
            tick();
            @(negedge clk);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== c0 || instr_cnt !== i0) begin
            errors++;
            $display("FAIL halt_counters cycle=%0d instr=%0d required %0d/%0d",
                     cycle_cnt, instr_cnt, c0, i0);
        end
`else
        checks++;
        if (cycle_cnt !== '0 || instr_cnt !== '0 || c0 !== '0 || i0 !== '0) begin
            errors++;
            $display("FAIL counters_tied cycle=%0d instr=%0d required 0/0", cycle_cnt, instr_cnt);
        end
`endif
        $display("illegal opcode: state=%0d illegal=%0d", state_dbg, illegal);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_ld();
        test_sd();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
